namco_wsg: RTL and testbench

- Parametrised Namco waveform sound generator (WSG). Successor to the fixed 3-voice audio logic in the Pacman top level.
- Supports NUM_CH voices (1..8) through a regular register map.
- Fetches wave samples through a req/ack ROM port, so ROM latency is free.
- Mixes all voices once per sample tick into a signed PCM word with a strobe; the HDMI audio packer consumes that word.

---
 rtl/namco_wsg_pkg.sv | 13 +
 rtl/namco_wsg_regfile.sv | 44 ++++
 rtl/namco_wsg.sv | 128 ++++++++++++
 tb/tb_namco_wsg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/namco_wsg_pkg.sv
// namco_wsg_pkg: shared FSM states, register indices and mix constants for the WSG
package namco_wsg_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, FETCH, ACC, OUT} state_t;
  localparam logic [2:0] REG_FREQ0 = 3'd0;
  localparam logic [2:0] REG_FREQ1 = 3'd1;
  localparam logic [2:0] REG_FREQ2 = 3'd2;
  localparam logic [2:0] REG_FREQ3 = 3'd3;
  localparam logic [2:0] REG_FREQ4 = 3'd4;
  localparam logic [2:0] REG_WAVE  = 3'd5;
  localparam logic [2:0] REG_VOL   = 3'd6;
  localparam int WAVE_BIAS = 8;
  localparam int MIX_W = 11;
endpackage

// File: rtl/namco_wsg_regfile.sv
// namco_wsg_regfile: per-voice nibble registers with write decode and a combinational voice select
module namco_wsg_regfile
  import namco_wsg_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = 20
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             reg_we,
  input  logic [5:0]       reg_addr,
  input  logic [3:0]       reg_wdata,
  input  logic [2:0]       sel,
  output logic [ACC_W-1:0] freq,
  output logic [3:0]       wave,
  output logic [3:0]       vol
);
  logic [3:0] regs [NUM_CH][7];
  // store nibbles; reserved idx7 and voices beyond NUM_CH never match the decode
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      for (int v = 0; v < NUM_CH; v++)
        for (int i = 0; i < 7; i++)
          regs[v][i] <= '0;
    end else if (reg_we) begin
      for (int v = 0; v < NUM_CH; v++)
        for (int i = 0; i < 7; i++)
          if (reg_addr == {3'(v), 3'(i)})
            regs[v][i] <= reg_wdata;
    end
  // present the selected voice's settings
  always_comb begin
    freq = '0;
    wave = '0;
    vol = '0;
    for (int v = 0; v < NUM_CH; v++)
      if (sel == 3'(v)) begin
        freq = ACC_W'({regs[v][REG_FREQ4], regs[v][REG_FREQ3], regs[v][REG_FREQ2],
                       regs[v][REG_FREQ1], regs[v][REG_FREQ0]});
        wave = regs[v][REG_WAVE];
        vol = regs[v][REG_VOL];
      end
  end
endmodule

// File: rtl/namco_wsg.sv
// namco_wsg: multi-voice wavetable sound generator; NAMCO_WSG_LPF_EN adds a one-pole output low-pass
module namco_wsg
  import namco_wsg_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int CLK_HZ    = 47828000,
  parameter int SAMPLE_HZ = 24000,
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 16
) (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  input  logic                    reg_we,
  input  logic [5:0]              reg_addr,
  input  logic [3:0]              reg_wdata,
  output logic                    wave_req,
  output logic [8:0]              wave_addr,
  input  logic                    wave_ack,
  input  logic [3:0]              wave_data,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_stb,
  output logic                    overrun
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = $clog2(DIV + 1);
  logic [CNT_W-1:0] cnt;
  logic tick;
  state_t state;
  logic [2:0] ch;
  logic [3:0] smp, wave, vol;
  logic [ACC_W-1:0] freq, acc_sel;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic signed [MIX_W-1:0] sum, term;
  logic signed [OUT_W-1:0] raw;
  namco_wsg_regfile #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) u_regs (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .sel(ch),
    .freq(freq),
    .wave(wave),
    .vol(vol)
  );
  assign tick = cnt == CNT_W'(DIV - 1);
  assign term = MIX_W'($signed({2'b00, vol})) * MIX_W'($signed({2'b00, smp}) - $signed(6'(WAVE_BIAS)));
  assign raw = OUT_W'(sum) << (OUT_W - MIX_W);
  // sample-rate divider
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  // phase of the voice being mixed
  always_comb begin
    acc_sel = '0;
    for (int v = 0; v < NUM_CH; v++)
      if (ch == 3'(v)) acc_sel = acc[v];
  end
  // phase accumulators advance once per mix, muted or not
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      for (int v = 0; v < NUM_CH; v++) acc[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_CH; v++)
        if (state == ACC && ch == 3'(v)) acc[v] <= acc[v] + freq;
    end
  // mix sequencer: walk the voices, fetch a sample for each audible one, accumulate
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ch <= '0;
      sum <= '0;
      smp <= '0;
      wave_req <= 1'b0;
      wave_addr <= '0;
      sample_stb <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      overrun <= tick && state != IDLE;
      case (state)
        IDLE: if (tick) begin
          state <= SETUP;
          ch <= '0;
          sum <= '0;
        end
        SETUP: if (vol == 4'd0) begin
          smp <= 4'(WAVE_BIAS);
          state <= ACC;
        end else begin
          wave_req <= 1'b1;
          wave_addr <= {wave, acc_sel[ACC_W-1 -: 5]};
          state <= FETCH;
        end
        FETCH: if (wave_ack) begin
          smp <= wave_data;
          wave_req <= 1'b0;
          state <= ACC;
        end
        ACC: begin
          sum <= sum + term;
          ch <= ch + 3'd1;
          state <= ch == 3'(NUM_CH - 1) ? OUT : SETUP;
        end
        OUT: begin
          sample_stb <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef NAMCO_WSG_LPF_EN
  logic signed [OUT_W+1:0] y, x;
  logic signed [OUT_W+2:0] d;
  assign x = {raw, 2'b00};
  assign d = (OUT_W+3)'(x) - (OUT_W+3)'(y);
  assign sample_out = y[OUT_W+1:2];
  // one-pole low-pass updated once per finished mix
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) y <= '0;
    else if (state == OUT) y <= y + (OUT_W+2)'(d >>> 2);
`else
  // latch the scaled mix when it completes
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) sample_out <= '0;
    else if (state == OUT) sample_out <= raw;
`endif
endmodule

// File: tb/tb_namco_wsg.sv
// tb_namco_wsg: directed checks of the WSG with a latency-configurable wave ROM model
module tb_namco_wsg;
  logic clk_pixel = 1'b0;
  logic reset_n = 1'b0;
  logic reg_we = 1'b0;
  logic [5:0] reg_addr = '0;
  logic [3:0] reg_wdata = '0;
  logic wave_req, wave_ack, sample_stb, overrun;
  logic [8:0] wave_addr;
  logic [3:0] wave_data;
  logic signed [15:0] sample_out;
  int checks = 0, errors = 0;
  int lat = 0, wcnt = 0;
  bit rom_zero = 1'b0;
  int cyc = 0, nstb = 0, nreq = 0, novr = 0, prev_stb = 0, last_stb = 0;
  bit req_d = 1'b0;
  int s0, r0, o0;

  namco_wsg dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .wave_req(wave_req),
    .wave_addr(wave_addr),
    .wave_ack(wave_ack),
    .wave_data(wave_data),
    .sample_out(sample_out),
    .sample_stb(sample_stb),
    .overrun(overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  // ROM: acks lat+1 cycles after seeing req; data is only meaningful during ack
  always @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      wave_ack <= 1'b0;
      wave_data <= 4'hF;
      wcnt <= 0;
    end else if (wave_req && !wave_ack) begin
      if (wcnt >= lat) begin
        wave_ack <= 1'b1;
        wave_data <= rom_zero ? 4'h0 : wave_addr[3:0];
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else begin
      wave_ack <= 1'b0;
      wave_data <= 4'hF;
    end

  // event counters sampled away from the active edge
  always @(negedge clk_pixel) begin
    cyc++;
    if (wave_req && !req_d) nreq++;
    req_d = wave_req;
    if (sample_stb) begin
      nstb++;
      prev_stb = last_stb;
      last_stb = cyc;
    end
    if (overrun) novr++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int v, input int i, input int d);
    @(negedge clk_pixel);
    reg_we = 1'b1;
    reg_addr = {3'(v), 3'(i)};
    reg_wdata = 4'(d);
    @(negedge clk_pixel);
    reg_we = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!sample_stb && n < 6000);
    if (!sample_stb) chk({tag, "_stb_timeout"}, 0, 1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!wave_req && n < 4000);
    if (!wave_req) chk({tag, "_req_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_pixel);
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_stb", int'(sample_stb), 0);
    chk("rst_req", int'(wave_req), 0);
    chk("rst_ovr", int'(overrun), 0);
    s0 = nstb;
    r0 = nreq;
    reset_n = 1'b1;
    repeat (3 * 1992 + 20) @(negedge clk_pixel);
    chk("idle_stb_cnt", nstb - s0, 3);
    chk("idle_req_cnt", nreq - r0, 0);
    chk("stb_period", last_stb - prev_stb, 1992);
    chk("idle_sample", int'(sample_out), 0);

    wait_stb("align");
    wr(0, 6, 15);
    wr(0, 5, 2);
    wr(0, 3, 8);
    for (int k = 0; k < 4; k++) begin
      wait_req("phase");
      chk($sformatf("phase_addr%0d", k), int'(wave_addr), 'h40 + k);
      wait_stb("phase");
      chk($sformatf("phase_sample%0d", k), int'(sample_out), 15 * (k - 8) * 32);
    end

    rom_zero = 1'b1;
    wr(1, 6, 15);
    wr(2, 6, 15);
    o0 = novr;
    wait_stb("fullneg");
    chk("fullneg_sample", int'(sample_out), -11520);
    chk("fullneg_ovr", novr - o0, 0);

    wait_req("midfetch");
    s0 = nstb;
    reset_n = 1'b0;
    #1;
    chk("async_req_drop", int'(wave_req), 0);
    repeat (5) @(negedge clk_pixel);
    chk("midfetch_no_stb", nstb - s0, 0);
    chk("midfetch_sample", int'(sample_out), 0);
    reset_n = 1'b1;

    wr(0, 0, 1);
    r0 = nreq;
    for (int k = 0; k < 5; k++) wait_stb("mute");
    chk("mute_req_cnt", nreq - r0, 0);
    chk("mute_sample", int'(sample_out), 0);
    wr(0, 6, 1);
    wait_req("unmute");
    chk("unmute_addr", int'(wave_addr), 0);
    wait_stb("unmute");
    chk("unmute_sample", int'(sample_out), -256);

    lat = 700;
    wr(0, 6, 15);
    wr(1, 6, 15);
    wr(2, 6, 15);
    o0 = novr;
    wait_stb("slow1");
    chk("slow1_sample", int'(sample_out), -11520);
    chk("slow_ovr", novr - o0, 1);
    wait_stb("slow2");
    chk("slow2_sample", int'(sample_out), -11520);

    lat = 20;
    wr(1, 6, 0);
    wr(4, 6, 0);
    wait_req("midmix");
    wr(1, 6, 15);
    wait_stb("midmix");
    chk("midmix_sample", int'(sample_out), -11520);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
